// File: rtl/cnn_clk_pkg.sv
// Shared clocking constants for the CNN accelerator strobe divider and its monitor.
package cnn_clk_pkg;

  localparam int CNT_W_DEFAULT   = 28;
  localparam int DIVISOR_DEFAULT = 38;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } mon_state_t;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for the divided strobe; history register freezes while disabled.
module rise_detect (
  input  logic clock_in,
  input  logic rst,
  input  logic en,
  input  logic strobe_in,
  output logic rise
);

  logic strobe_d;

  always_ff @(posedge clock_in) begin
    if (rst) begin
      strobe_d <= 1'b0;
    end else if (en) begin
      strobe_d <= strobe_in;
    end
  end

  assign rise = en & strobe_in & ~strobe_d;

endmodule

// File: rtl/strobe_period_monitor.sv
// Measures strobe period and high time in clock_in cycles, flags rate errors, tracks lock.
module strobe_period_monitor
  import cnn_clk_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEFAULT,
  parameter int EXP_PERIOD = DIVISOR_DEFAULT,
  parameter int EXP_HIGH   = 1,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clock_in,
  input  logic             rst,
  input  logic             en,
  input  logic             strobe_in,
  input  logic             clear_err,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             locked,
  output logic             err_period,
  output logic             err_high,
  output logic             err_timeout,
  output logic             err_sticky
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   EXP_P_W  = (CNT_W+1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]   EXP_H_W  = (CNT_W+1)'(EXP_HIGH);
  localparam logic [CNT_W:0]   TOL_W    = (CNT_W+1)'(TOL);
  localparam logic [3:0]       LOCK_W   = 4'(LOCK_COUNT);

  mon_state_t       state;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [3:0]       lock_cnt;
  logic             rise;

  logic [CNT_W:0]   period_ext;
  logic [CNT_W:0]   high_ext;
  logic [CNT_W:0]   period_diff;
  logic [CNT_W:0]   high_diff;
  logic             period_bad;
  logic             high_bad;
  logic             capture;
  logic             timeout_hit;
  logic             err_any;

  rise_detect u_rise_detect (
    .clock_in  (clock_in),
    .rst       (rst),
    .en        (en),
    .strobe_in (strobe_in),
    .rise      (rise)
  );

  // Differences are taken one bit wider than the counters so they never wrap.
  always_comb begin
    period_ext  = {1'b0, period_cnt};
    high_ext    = {1'b0, high_cnt};
    period_diff = (period_ext >= EXP_P_W) ? (period_ext - EXP_P_W) : (EXP_P_W - period_ext);
    high_diff   = (high_ext >= EXP_H_W) ? (high_ext - EXP_H_W) : (EXP_H_W - high_ext);
    period_bad  = (period_diff > TOL_W);
    high_bad    = (high_diff > TOL_W);
    capture     = en && (state == MEASURE) && rise;
    timeout_hit = en && (state == MEASURE) && !rise && (period_cnt == CNT_MAX);
    err_any     = (capture && (period_bad || high_bad)) || timeout_hit;
  end

  assign locked = (lock_cnt == LOCK_W);

  always_ff @(posedge clock_in) begin
    if (rst) begin
      state       <= IDLE;
      period_cnt  <= '0;
      high_cnt    <= '0;
      lock_cnt    <= '0;
      period_out  <= '0;
      high_out    <= '0;
      meas_valid  <= 1'b0;
      err_period  <= 1'b0;
      err_high    <= 1'b0;
      err_timeout <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      meas_valid  <= capture;
      err_period  <= capture && period_bad;
      err_high    <= capture && high_bad;
      err_timeout <= timeout_hit;

      if (err_any) begin
        err_sticky <= 1'b1;
      end else if (clear_err) begin
        err_sticky <= 1'b0;
      end

      if (capture) begin
        period_out <= period_cnt;
        high_out   <= high_cnt;
        if (period_bad || high_bad) begin
          lock_cnt <= '0;
        end else if (lock_cnt != LOCK_W) begin
          lock_cnt <= lock_cnt + 4'd1;
        end
      end else if (timeout_hit) begin
        lock_cnt <= '0;
      end

      // The rise cycle itself is the first cycle of the new period, hence restart at 1.
      if (en) begin
        case (state)
          IDLE: begin
            if (rise) begin
              state      <= MEASURE;
              period_cnt <= CNT_ONE;
              high_cnt   <= CNT_ONE;
            end
          end
          MEASURE: begin
            if (rise) begin
              period_cnt <= CNT_ONE;
              high_cnt   <= CNT_ONE;
            end else if (period_cnt == CNT_MAX) begin
              state <= IDLE;
            end else begin
              period_cnt <= period_cnt + CNT_ONE;
              high_cnt   <= high_cnt + {{(CNT_W-1){1'b0}}, strobe_in};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_strobe_period_monitor.sv
// Randomised directed bench for strobe_period_monitor against a sample-history reference model.
module tb_strobe_period_monitor;

  localparam int CNT_W = 6;
  localparam int EXP_P = 38;
  localparam int EXP_H = 1;
  localparam int TOL   = 0;
  localparam int LOCK  = 4;

  logic             clock_in = 1'b0;
  logic             rst;
  logic             en;
  logic             strobe_in;
  logic             clear_err;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             meas_valid;
  logic             locked;
  logic             err_period;
  logic             err_high;
  logic             err_timeout;
  logic             err_sticky;

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: the strobe samples seen since the last counted rise.
  bit m_armed;
  bit m_prev;
  int m_lock;
  bit m_hist[$];
  int e_period, e_high;
  bit e_mv, e_ep, e_eh, e_to, e_sticky;
  bit g_clr;

  strobe_period_monitor #(
    .CNT_W      (CNT_W),
    .EXP_PERIOD (EXP_P),
    .EXP_HIGH   (EXP_H),
    .TOL        (TOL),
    .LOCK_COUNT (LOCK)
  ) dut (
    .clock_in    (clock_in),
    .rst         (rst),
    .en          (en),
    .strobe_in   (strobe_in),
    .clear_err   (clear_err),
    .period_out  (period_out),
    .high_out    (high_out),
    .meas_valid  (meas_valid),
    .locked      (locked),
    .err_period  (err_period),
    .err_high    (err_high),
    .err_timeout (err_timeout),
    .err_sticky  (err_sticky)
  );

  always #5 clock_in = ~clock_in;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    assert (act === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic model(input bit r, input bit e, input bit s, input bit c);
    bit rise;
    int p, h;
    e_mv = 0; e_ep = 0; e_eh = 0; e_to = 0;
    if (r) begin
      m_armed = 0; m_prev = 0; m_lock = 0; m_hist.delete();
      e_period = 0; e_high = 0; e_sticky = 0;
    end else begin
      if (e) begin
        rise   = s && !m_prev;
        m_prev = s;
        if (!m_armed) begin
          if (rise) begin
            m_armed = 1;
            m_hist.delete();
            m_hist.push_back(s);
          end
        end else if (rise) begin
          p = m_hist.size();
          h = 0;
          foreach (m_hist[i]) h += int'(m_hist[i]);
          e_period = p;
          e_high   = h;
          e_mv     = 1;
          e_ep     = absdiff(p, EXP_P) > TOL;
          e_eh     = absdiff(h, EXP_H) > TOL;
          if (e_ep || e_eh) m_lock = 0;
          else if (m_lock < LOCK) m_lock++;
          m_hist.delete();
          m_hist.push_back(s);
        end else if (m_hist.size() == (1 << CNT_W) - 1) begin
          e_to    = 1;
          m_lock  = 0;
          m_armed = 0;
          m_hist.delete();
        end else begin
          m_hist.push_back(s);
        end
      end
      if (e_ep || e_eh || e_to) e_sticky = 1;
      else if (c) e_sticky = 0;
    end
  endtask

  task automatic checkOutput();
    chk("period_out",  32'(period_out),  32'(e_period));
    chk("high_out",    32'(high_out),    32'(e_high));
    chk("meas_valid",  32'(meas_valid),  32'(e_mv));
    chk("locked",      32'(locked),      32'(m_lock == LOCK));
    chk("err_period",  32'(err_period),  32'(e_ep));
    chk("err_high",    32'(err_high),    32'(e_eh));
    chk("err_timeout", 32'(err_timeout), 32'(e_to));
    chk("err_sticky",  32'(err_sticky),  32'(e_sticky));
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit s, input bit c);
    rst       = r;
    en        = e;
    strobe_in = s;
    clear_err = c;
    model(r, e, s, c);
    @(posedge clock_in);
    #1;
    checkOutput();
  endtask

  // One strobe period of p enabled cycles with h high cycles; optional disabled gap at cycle gap_at.
  task automatic run_period(input int p, input int h, input int gap_at, input int gap_len);
    for (int i = 0; i < p; i++) begin
      if (i == gap_at) begin
        for (int k = 0; k < gap_len; k++) applyStimulus(0, 0, 1'($urandom_range(0, 1)), g_clr);
      end
      applyStimulus(0, 1, i < h, g_clr);
    end
  endtask

  initial begin
    int p, h, sel;
    g_clr     = 0;
    rst       = 1;
    en        = 0;
    strobe_in = 0;
    clear_err = 0;

    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);

    // Nominal divider strobe until locked.
    for (int i = 0; i < 6; i++) run_period(EXP_P, 1, -1, 0);

    // Stretched period after lock, then relock; sticky held until cleared.
    run_period(40, 1, -1, 0);
    for (int i = 0; i < 5; i++) run_period(EXP_P, 1, -1, 0);
    applyStimulus(0, 1, 1, 1);
    run_period(EXP_P - 1, 0, -1, 0);

    // Wide high pulse at the nominal period.
    run_period(EXP_P, 3, -1, 0);
    run_period(EXP_P, 1, -1, 0);

    // Enable dropped mid-period.
    run_period(EXP_P, 1, 15, 10);
    run_period(EXP_P, 1, -1, 0);

    // clear_err held across a bad measurement: the error must win.
    run_period(EXP_P, 1, -1, 0);
    g_clr = 1;
    run_period(EXP_P + 2, 1, -1, 0);
    run_period(3, 1, -1, 0);
    g_clr = 0;
    for (int i = 0; i < 3; i++) run_period(EXP_P, 1, -1, 0);

    // Randomised jitter, high width, enable gaps and clears.
    for (int n = 0; n < 25; n++) begin
      sel   = int'($urandom_range(0, 7));
      p     = (sel == 0) ? EXP_P - 1 : (sel == 1) ? EXP_P + 1 : EXP_P;
      h     = ($urandom_range(0, 5) == 0) ? 2 : 1;
      g_clr = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0)
        run_period(p, h, int'($urandom_range(h, p - 1)), int'($urandom_range(1, 12)));
      else
        run_period(p, h, -1, 0);
    end
    g_clr = 0;

    // Relock, then stop the strobe so the counter saturates.
    for (int i = 0; i < 5; i++) run_period(EXP_P, 1, -1, 0);
    run_period(80, 1, -1, 0);
    for (int i = 0; i < 6; i++) run_period(EXP_P, 1, -1, 0);

    // Constantly high strobe has no further rise.
    run_period(75, 75, -1, 0);
    for (int i = 0; i < 3; i++) run_period(EXP_P, 1, -1, 0);

    // Reset in the middle of a measurement.
    run_period(40, 1, -1, 0);
    run_period(12, 1, -1, 0);
    applyStimulus(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) run_period(EXP_P, 1, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
